mem_stage: RTL

Memory-access stage of the five-stage MIPS pipeline, consuming the EX/MEM pipeline register. Non-memory instructions pass through in one cycle. Loads and stores run a request/acknowledge transaction on a variable-latency data-memory port, with a timeout. The stage stalls upstream stages while a transaction is open and registers the MEM/WB values consumed by write-back.

---
 rtl/mem_stage.sv | 121 ++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
//==============================================================================
// Module   : mem_stage
// Purpose  : MIPS MEM stage - req/ack data-memory port with timeout abort,
//            upstream stall and registered MEM/WB outputs.
// Revision : 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module mem_stage #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] ALUoutputData_ex,
   input  logic [31:0] rtData_ex,
   input  logic [4:0]  RegFileWtAddr_ex,
   input  logic        wmem_ex,
   input  logic        Mem2Reg_ex,
   input  logic        wreg_ex,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic        stall_mem,
   output logic [31:0] RegFileWtData_mem,
   output logic [4:0]  RegFileWtAddr_mem,
   output logic        wreg_mem,
   output logic        align_err,
   output logic        bus_err
);

   localparam int              c_CW   = $clog2(TIMEOUT) + 1;
   localparam logic [c_CW-1:0] c_LAST = c_CW'(TIMEOUT - 1);
   localparam logic [c_CW-1:0] c_CMAX = '1;
   localparam logic [0:0]      c_IDLE = 1'b0;
   localparam logic [0:0]      c_WAIT = 1'b1;

   logic [0:0]      r_state;
   logic [c_CW-1:0] r_cnt;

   logic w_access;
   logic w_misaligned;
   logic w_start;
   logic w_in_wait;
   logic w_abort;
   logic w_load_only;

   always_comb begin
      w_access     = wmem_ex | Mem2Reg_ex;
      w_misaligned = (ALUoutputData_ex[1:0] != 2'b00);
      w_start      = (r_state == c_IDLE) & w_access & ~w_misaligned;
      w_in_wait    = (r_state == c_WAIT);
      // Ack wins over abort when both land in the last allowed cycle.
      w_abort      = w_in_wait & ~dmem_ack & (r_cnt == c_LAST);
      w_load_only  = Mem2Reg_ex & ~wmem_ex;
   end

   assign stall_mem = reset & (w_start | (w_in_wait & ~dmem_ack & ~w_abort));

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state           <= c_IDLE;
         r_cnt             <= '0;
         dmem_req          <= 1'b0;
         dmem_we           <= 1'b0;
         dmem_addr         <= '0;
         dmem_wdata        <= '0;
         RegFileWtData_mem <= '0;
         RegFileWtAddr_mem <= '0;
         wreg_mem          <= 1'b0;
         align_err         <= 1'b0;
         bus_err           <= 1'b0;
      end else begin
         align_err         <= (r_state == c_IDLE) & w_access & w_misaligned;
         bus_err           <= w_abort;
         // MEM/WB carries a bubble unless an instruction retires this cycle.
         RegFileWtData_mem <= '0;
         RegFileWtAddr_mem <= '0;
         wreg_mem          <= 1'b0;

         case (r_state)
            c_IDLE: begin
               if (!w_access) begin
                  RegFileWtData_mem <= ALUoutputData_ex;
                  RegFileWtAddr_mem <= RegFileWtAddr_ex;
                  wreg_mem          <= wreg_ex;
               end else if (w_start) begin
                  dmem_req   <= 1'b1;
                  dmem_we    <= wmem_ex;
                  dmem_addr  <= {ALUoutputData_ex[31:2], 2'b00};
                  dmem_wdata <= rtData_ex;
                  r_state    <= c_WAIT;
                  r_cnt      <= '0;
               end
            end
            default: begin
               if (dmem_ack) begin
                  dmem_req          <= 1'b0;
                  r_state           <= c_IDLE;
                  r_cnt             <= '0;
                  RegFileWtData_mem <= w_load_only ? dmem_rdata : ALUoutputData_ex;
                  RegFileWtAddr_mem <= RegFileWtAddr_ex;
                  wreg_mem          <= wreg_ex;
               end else if (w_abort) begin
                  dmem_req <= 1'b0;
                  r_state  <= c_IDLE;
                  r_cnt    <= '0;
               end else if (r_cnt != c_CMAX) begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
         endcase
      end
   end

endmodule

`default_nettype wire
